echo_request_arbiter: RTL and testbench

Two-client scheduler in front of the echo request input pipe. Each client pushes 192-bit request messages into its own small FIFO. A round-robin arbiter forwards one valid message per cycle onto the downstream `pipe$enq` port. Messages whose tag is neither say (1) nor say2 (2) are discarded and counted, so the downstream decoder only ever sees legal tags.

---
 rtl/echo_request_pkg.sv | 36 +++
 rtl/echo_request_fifo.sv | 59 +++++
 rtl/echo_request_arbiter.sv | 131 +++++++++++++
 tb/tb_echo_request_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/echo_request_pkg.sv
// Shared definitions for the echo request arbiter: message layout, legal tags and
// head classification.
package echo_request_pkg;

    localparam int unsigned ECHO_MSG_W = 192;
    localparam int unsigned FIELD_W    = 32;

    localparam logic [FIELD_W-1:0] TAG_SAY  = 32'd1;
    localparam logic [FIELD_W-1:0] TAG_SAY2 = 32'd2;

    localparam int unsigned TAG_LSB       = 0;
    localparam int unsigned SAY_METH_LSB  = 32;
    localparam int unsigned SAY_V_LSB     = 64;
    localparam int unsigned SAY2_METH_LSB = 96;
    localparam int unsigned SAY2_V_LSB    = 128;

    typedef enum logic [1:0] {
        HeadEmpty = 2'd0,
        HeadGood  = 2'd1,
        HeadBad   = 2'd2
    } head_class_e;

    function automatic head_class_e classify_head(input logic valid,
                                                  input logic [ECHO_MSG_W-1:0] msg);
        logic [FIELD_W-1:0] tag;
        tag = msg[TAG_LSB +: FIELD_W];
        if (!valid) begin
            return HeadEmpty;
        end
        if (tag == TAG_SAY || tag == TAG_SAY2) begin
            return HeadGood;
        end
        return HeadBad;
    endfunction

endpackage

// File: rtl/echo_request_fifo.sv
// Per-client request FIFO: no bypass, a push while full is ignored, pop of an empty
// FIFO is ignored.
module echo_request_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 192
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (PTR_W + 1)'(DEPTH));
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr_q];

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/echo_request_arbiter.sv
// Two-client round-robin scheduler in front of the echo request pipe; heads with
// illegal tags are dropped and counted.
module echo_request_arbiter
    import echo_request_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  client0_enq__ENA,
    input  logic [ECHO_MSG_W-1:0] client0_enq_v,
    output logic                  client0_enq__RDY,
    input  logic                  client1_enq__ENA,
    input  logic [ECHO_MSG_W-1:0] client1_enq_v,
    output logic                  client1_enq__RDY,
    output logic                  pipe_enq__ENA,
    output logic [ECHO_MSG_W-1:0] pipe_enq_v,
    input  logic                  pipe_enq__RDY,
    output logic [CNT_W-1:0]      drop_count
);

    logic [ECHO_MSG_W-1:0] head0;
    logic [ECHO_MSG_W-1:0] head1;
    logic                  empty0;
    logic                  empty1;
    logic                  full0;
    logic                  full1;
    logic                  pop0;
    logic                  pop1;
    head_class_e           class0;
    head_class_e           class1;
    logic                  good0;
    logic                  good1;
    logic                  bad0;
    logic                  bad1;
    logic                  grant0;
    logic                  grant1;
    logic                  last_q;
    logic                  last_d;
    logic [CNT_W-1:0]      drop_q;
    logic [CNT_W-1:0]      drop_d;
    logic [1:0]            drop_inc;
    logic [CNT_W:0]        drop_sum;

    echo_request_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ECHO_MSG_W)
    ) u_fifo0 (
        .clk       (CLK),
        .rst       (RST),
        .push      (client0_enq__ENA),
        .push_data (client0_enq_v),
        .pop       (pop0),
        .head      (head0),
        .empty     (empty0),
        .full      (full0)
    );

    echo_request_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ECHO_MSG_W)
    ) u_fifo1 (
        .clk       (CLK),
        .rst       (RST),
        .push      (client1_enq__ENA),
        .push_data (client1_enq_v),
        .pop       (pop1),
        .head      (head1),
        .empty     (empty1),
        .full      (full1)
    );

    assign client0_enq__RDY = ~full0;
    assign client1_enq__RDY = ~full1;

    assign class0 = classify_head(~empty0, head0);
    assign class1 = classify_head(~empty1, head1);
    assign good0  = (class0 == HeadGood);
    assign good1  = (class1 == HeadGood);
    assign bad0   = (class0 == HeadBad);
    assign bad1   = (class1 == HeadBad);

    // On contention the client that did not win last time is served.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (pipe_enq__RDY) begin
            if (good0 && (!good1 || last_q)) begin
                grant0 = 1'b1;
            end else if (good1) begin
                grant1 = 1'b1;
            end
        end
    end

    always_comb begin
        last_d = last_q;
        if (grant0) begin
            last_d = 1'b0;
        end else if (grant1) begin
            last_d = 1'b1;
        end
    end

    // Bad heads leave regardless of downstream readiness.
    assign pop0 = bad0 | grant0;
    assign pop1 = bad1 | grant1;

    assign pipe_enq__ENA = grant0 | grant1;
    assign pipe_enq_v    = grant0 ? head0 : (grant1 ? head1 : '0);

    always_comb begin
        drop_inc = {1'b0, bad0} + {1'b0, bad1};
        drop_sum = {1'b0, drop_q} + (CNT_W + 1)'(drop_inc);
        drop_d   = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
    end

    assign drop_count = drop_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            last_q <= 1'b1;
            drop_q <= '0;
        end else begin
            last_q <= last_d;
            drop_q <= drop_d;
        end
    end

endmodule

// File: tb/tb_echo_request_arbiter.sv
// Self-checking bench for echo_request_arbiter: vector table, hand sequences and a
// randomized run against a queue-based reference model.
module tb_echo_request_arbiter;
    import echo_request_pkg::*;

    localparam int unsigned DEPTH   = 2;
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned W       = ECHO_MSG_W;
    localparam int unsigned CNT_MAX = 65535;

    logic             clk;
    logic             rst;
    logic             c0_ena;
    logic [W-1:0]     c0_v;
    logic             c0_rdy;
    logic             c1_ena;
    logic [W-1:0]     c1_v;
    logic             c1_rdy;
    logic             p_ena;
    logic [W-1:0]     p_v;
    logic             prdy;
    logic [CNT_W-1:0] drop;

    echo_request_arbiter #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .CLK              (clk),
        .RST              (rst),
        .client0_enq__ENA (c0_ena),
        .client0_enq_v    (c0_v),
        .client0_enq__RDY (c0_rdy),
        .client1_enq__ENA (c1_ena),
        .client1_enq_v    (c1_v),
        .client1_enq__RDY (c1_rdy),
        .pipe_enq__ENA    (p_ena),
        .pipe_enq_v       (p_v),
        .pipe_enq__RDY    (prdy),
        .drop_count       (drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    int           total = 0;
    int           bad   = 0;
    logic [W-1:0] q0[$];
    logic [W-1:0] q1[$];
    logic [W-1:0] fwd_log[$];
    bit           last_m;
    int unsigned  drop_m;
    logic [15:0]  seq;

    typedef struct {
        bit          e0;
        logic [31:0] t0;
        bit          e1;
        logic [31:0] t1;
        bit          rdy;
        bit          exp_ena;
        bit          exp_win;
        int unsigned exp_inc;
    } vec_t;

    vec_t tbl[8];

    function automatic logic [W-1:0] mk(input logic [31:0] tag, input bit client,
                                        input logic [15:0] s);
        logic [W-1:0] m;
        m = '0;
        m[TAG_LSB +: FIELD_W]       = tag;
        m[SAY_METH_LSB +: FIELD_W]  = $urandom;
        m[SAY_V_LSB +: FIELD_W]     = $urandom;
        m[SAY2_METH_LSB +: FIELD_W] = $urandom;
        m[SAY2_V_LSB +: FIELD_W]    = $urandom;
        m[160]                      = client;
        m[191:176]                  = s;
        return m;
    endfunction

    function automatic bit is_good(input logic [W-1:0] m);
        return (m[31:0] == 32'd1) || (m[31:0] == 32'd2);
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        c0_ena = 1'b0;
        c1_ena = 1'b0;
    endtask

    // Called just after a falling edge with inputs driven; returns after the next one.
    task automatic step();
        bit           g0, g1, b0, b1, fwd, w, acc0, acc1;
        logic [W-1:0] ev;
        int unsigned  sum;
        #1;
        g0   = (q0.size() > 0) && is_good(q0[0]);
        b0   = (q0.size() > 0) && !is_good(q0[0]);
        g1   = (q1.size() > 0) && is_good(q1[0]);
        b1   = (q1.size() > 0) && !is_good(q1[0]);
        w    = (g0 && g1) ? !last_m : g1;
        fwd  = prdy && (g0 || g1);
        ev   = !fwd ? '0 : (w ? q1[0] : q0[0]);
        acc0 = c0_ena && (q0.size() < DEPTH);
        acc1 = c1_ena && (q1.size() < DEPTH);
        check("rdy0", W'(c0_rdy), W'(q0.size() < DEPTH));
        check("rdy1", W'(c1_rdy), W'(q1.size() < DEPTH));
        check("pipe_ena", W'(p_ena), W'(fwd));
        check("pipe_v", p_v, ev);
        check("drop_count", W'(drop), W'(drop_m));
        if (c0_ena && !acc0) $display("note: illegal push on client0 while full");
        if (c1_ena && !acc1) $display("note: illegal push on client1 while full");
        @(posedge clk);
        if (b0) void'(q0.pop_front());
        if (b1) void'(q1.pop_front());
        if (fwd) begin
            if (w) fwd_log.push_back(q1.pop_front());
            else   fwd_log.push_back(q0.pop_front());
            last_m = w;
        end
        if (acc0) q0.push_back(c0_v);
        if (acc1) q1.push_back(c1_v);
        sum    = drop_m + int'(b0) + int'(b1);
        drop_m = (sum > CNT_MAX) ? CNT_MAX : sum;
        @(negedge clk);
    endtask

    task automatic model_reset();
        q0.delete();
        q1.delete();
        last_m = 1'b1;
        drop_m = 0;
    endtask

    initial begin
        logic [W-1:0] m0, m1, m2;
        int unsigned  tbl_drop;
        int unsigned  n_push;
        int unsigned  extra;
        logic [15:0]  nxt[2];
        int           r;

        tbl[0] = '{1, 32'd1, 0, 32'd0, 1, 1, 0, 0};
        tbl[1] = '{1, 32'd2, 1, 32'd1, 1, 1, 1, 0};
        tbl[2] = '{1, 32'd7, 1, 32'd0, 1, 0, 0, 2};
        tbl[3] = '{1, 32'd1, 1, 32'd2, 0, 0, 0, 0};
        tbl[4] = '{1, 32'd5, 1, 32'd2, 1, 1, 1, 1};
        tbl[5] = '{1, 32'd2, 1, 32'd2, 1, 1, 0, 0};
        tbl[6] = '{1, 32'hFFFF_FFFF, 0, 32'd0, 0, 0, 0, 1};
        tbl[7] = '{0, 32'd0, 1, 32'd1, 0, 0, 0, 0};

        seq    = 0;
        rst    = 1'b1;
        prdy   = 1'b0;
        c0_v   = '0;
        c1_v   = '0;
        idle();
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_rdy0", W'(c0_rdy), W'(1));
        check("reset_rdy1", W'(c1_rdy), W'(1));
        check("reset_ena", W'(p_ena), W'(0));
        check("reset_v", p_v, '0);
        check("reset_drop", W'(drop), W'(0));
        @(negedge clk);

        // Vector table: push in one cycle, observe the forward decision in the next.
        tbl_drop = 0;
        for (int i = 0; i < 8; i++) begin
            m0 = mk(tbl[i].t0, 0, seq++);
            m1 = mk(tbl[i].t1, 1, seq++);
            c0_ena = tbl[i].e0;
            c0_v   = m0;
            c1_ena = tbl[i].e1;
            c1_v   = m1;
            prdy   = 1'b0;
            step();
            idle();
            prdy = tbl[i].rdy;
            #1;
            check("tbl_ena", W'(p_ena), W'(tbl[i].exp_ena));
            if (tbl[i].exp_ena) check("tbl_data", p_v, tbl[i].exp_win ? m1 : m0);
            step();
            tbl_drop += tbl[i].exp_inc;
            check("tbl_drop", W'(drop), W'(tbl_drop));
            prdy = 1'b1;
            step();
            step();
        end

        // Push-to-forward latency with a fixed payload.
        m0 = mk(32'd1, 0, seq++);
        m0[63:32] = 32'h10;
        m0[95:64] = 32'hAA;
        c0_ena = 1'b1;
        c0_v   = m0;
        prdy   = 1'b1;
        #1;
        check("lat_same_cycle", W'(p_ena), W'(0));
        step();
        idle();
        #1;
        check("lat_next_ena", W'(p_ena), W'(1));
        check("lat_next_data", p_v, m0);
        step();

        // Backpressure: two pushes fill client 0, a third is illegal and ignored.
        prdy = 1'b0;
        m1 = mk(32'd1, 0, seq++);
        m2 = mk(32'd2, 0, seq++);
        c0_ena = 1'b1;
        c0_v   = m1;
        step();
        c0_v = m2;
        step();
        #1;
        check("bp_full_rdy0", W'(c0_rdy), W'(0));
        c0_v = mk(32'd1, 0, seq++);
        step();
        idle();
        prdy = 1'b1;
        fwd_log.delete();
        step();
        step();
        check("bp_count", W'(fwd_log.size()), W'(2));
        if (fwd_log.size() == 2) begin
            check("bp_first", fwd_log[0], m1);
            check("bp_second", fwd_log[1], m2);
        end
        #1;
        check("bp_rdy_back", W'(c0_rdy), W'(1));
        check("bp_no_third", W'(p_ena), W'(0));
        step();

        // Asynchronous reset with both FIFOs loaded.
        prdy   = 1'b0;
        c0_ena = 1'b1;
        c1_ena = 1'b1;
        for (int i = 0; i < 2; i++) begin
            c0_v = mk(32'd1, 0, seq++);
            c1_v = mk(32'd6, 1, seq++);
            step();
        end
        idle();
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_ena", W'(p_ena), W'(0));
        check("rst_mid_v", p_v, '0);
        check("rst_mid_rdy0", W'(c0_rdy), W'(1));
        check("rst_mid_rdy1", W'(c1_rdy), W'(1));
        check("rst_mid_drop", W'(drop), W'(0));
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        prdy = 1'b1;
        step();

        // Both clients push whenever space allows: grants alternate starting at client 0.
        fwd_log.delete();
        n_push = 0;
        nxt[0] = 0;
        nxt[1] = 0;
        for (int i = 0; i < 8; i++) begin
            c0_ena = (q0.size() < DEPTH);
            c1_ena = (q1.size() < DEPTH);
            c0_v   = mk(32'd2, 0, nxt[0]);
            c1_v   = mk(32'd2, 1, nxt[1]);
            if (c0_ena) begin nxt[0]++; n_push++; end
            if (c1_ena) begin nxt[1]++; n_push++; end
            step();
        end
        idle();
        repeat (4) step();
        check("alt_count", W'(fwd_log.size()), W'(n_push));
        nxt[0] = 0;
        nxt[1] = 0;
        for (int i = 0; i < fwd_log.size(); i++) begin
            if (i < 7) check("alt_grant", W'(fwd_log[i][160]), W'(i % 2));
            check("alt_order", W'(fwd_log[i][191:176]), W'(nxt[fwd_log[i][160]]));
            nxt[fwd_log[i][160]]++;
        end

        // Randomized traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            for (int c = 0; c < 2; c++) begin
                logic [31:0] t;
                r = $urandom_range(0, 5);
                t = (r == 0) ? 32'd0 : (r <= 2) ? 32'd1 : (r <= 4) ? 32'd2 : $urandom;
                if (c == 0) begin
                    c0_ena = ($urandom_range(0, 1) == 1) && (q0.size() < DEPTH);
                    c0_v   = mk(t, 0, seq++);
                end else begin
                    c1_ena = ($urandom_range(0, 1) == 1) && (q1.size() < DEPTH);
                    c1_v   = mk(t, 1, seq++);
                end
            end
            prdy = ($urandom_range(0, 3) != 0);
            step();
        end
        idle();
        prdy = 1'b1;
        repeat (4) step();

        // Drive bad tags on both clients until the drop counter saturates.
        extra = 0;
        for (int i = 0; i < 40000; i++) begin
            c0_ena = (q0.size() < DEPTH);
            c1_ena = (q1.size() < DEPTH);
            c0_v   = mk(32'd7, 0, seq++);
            c1_v   = mk(32'd0, 1, seq++);
            prdy   = $urandom_range(0, 1);
            step();
            if (drop_m == CNT_MAX) begin
                extra++;
                if (extra >= 4) break;
            end
        end
        idle();
        #1;
        check("sat_drop", W'(drop), W'(16'hFFFF));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
